uart_rx_ctrl: RTL and testbench

//   Host-to-FPGA serial receiver: the inbound counterpart of the 64-bit UART transmit path.

---
 rtl/uart_rx_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// 8N1 serial receiver that assembles BYTES bytes into one command word with a valid strobe.
// Optional macro RX_PARITY_EN switches the frame to 8E1 and adds the par_err strobe.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned BYTES        = 8,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [8*BYTES-1:0] rx_reg,
  output logic               rx_dv,
  output logic               rx_busy,
  output logic               frame_err,
  output logic [7:0]         err_cnt
`ifdef RX_PARITY_EN
  ,
  output logic               par_err
`endif
);

  localparam int unsigned CW     = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW     = $clog2(TO_CYC + 1);
  localparam int unsigned IW     = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [8*BYTES-1:0] word_q, word_d;
  logic [8*BYTES-1:0] rx_reg_q, rx_reg_d;
  logic               dv_q, dv_d;
  logic               ferr_q, ferr_d;
  logic [7:0]         err_q, err_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic               err_inc;
  logic               byte_ok;

`ifdef RX_PARITY_EN
  logic perr_q, perr_d;
  logic pbad_q, pbad_d;
  assign byte_ok = ~pbad_q;
`else
  assign byte_ok = 1'b1;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      rx_reg_q <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      err_q    <= '0;
      idle_q   <= '0;
`ifdef RX_PARITY_EN
      perr_q   <= 1'b0;
      pbad_q   <= 1'b0;
`endif
    end else begin
      sync_q   <= {sync_q[0], rx};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      rx_reg_q <= rx_reg_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
`ifdef RX_PARITY_EN
      perr_q   <= perr_d;
      pbad_q   <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    word_d   = word_q;
    rx_reg_d = rx_reg_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    err_inc  = 1'b0;
    idle_d   = '0;
`ifdef RX_PARITY_EN
    perr_d   = 1'b0;
    pbad_d   = pbad_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end else if (idx_q != '0) begin
          // Partial word ages out only while the line sits idle between frames
          if (idle_q == TO_LAST) begin
            idx_d = '0;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
      end

      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
`ifdef RX_PARITY_EN
            pbad_d  = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if ((^shift_q) != rx_s) begin
            perr_d  = 1'b1;
            pbad_d  = 1'b1;
            err_inc = 1'b1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s) begin
            // Return mid-stop-bit so the next start edge is never missed
            state_d = S_IDLE;
            if (byte_ok) begin
              word_d[8*(BYTES-1-int'(idx_q)) +: 8] = shift_q;
              if (idx_q == IDX_LAST) begin
                rx_reg_d = word_d;
                dv_d     = 1'b1;
                idx_d    = '0;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
          end else begin
            state_d = S_BREAK;
            ferr_d  = 1'b1;
            err_inc = 1'b1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  assign rx_reg    = rx_reg_q;
  assign rx_dv     = dv_q;
  assign frame_err = ferr_q;
  assign err_cnt   = err_q;
  assign rx_busy   = (state_q != S_IDLE) || (idx_q != '0);
`ifdef RX_PARITY_EN
  assign par_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at default parameters; drives rx on negedges, samples on negedges.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 87;
`ifdef RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [63:0] rx_reg;
  logic        rx_dv;
  logic        rx_busy;
  logic        frame_err;
  logic [7:0]  err_cnt;
`ifdef RX_PARITY_EN
  logic        par_err;
`endif

  int total = 0;
  int bad   = 0;

  int unsigned cyc       = 0;
  int unsigned dv_cnt    = 0;
  int unsigned fe_cnt    = 0;
  int unsigned pe_cnt    = 0;
  int unsigned clash_cnt = 0;
  int unsigned dv_cyc    = 0;
  int unsigned start_cyc = 0;
  logic [63:0] last_word = '0;
  logic [7:0]  exp_err   = '0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(87),
    .BYTES(8),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_reg(rx_reg),
    .rx_dv(rx_dv),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .err_cnt(err_cnt)
`ifdef RX_PARITY_EN
    ,
    .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_dv) begin
      dv_cnt    = dv_cnt + 1;
      dv_cyc    = cyc;
      last_word = rx_reg;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (rx_dv && frame_err) clash_cnt = clash_cnt + 1;
`ifdef RX_PARITY_EN
    if (par_err) pe_cnt = pe_cnt + 1;
    if (rx_dv && par_err) clash_cnt = clash_cnt + 1;
`endif
  end

  // start_cyc is the first posedge that can see the falling start edge
  task automatic send_frame_raw(input logic [7:0] d, input bit use_par, input logic par,
                                input logic stop);
    rx = 1'b0;
    start_cyc = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (use_par) begin
      rx = par;
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_frame_raw(d, PAR_ON, ^d, 1'b1);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_frame(w[63-8*i -: 8]);
  endtask

  task automatic idle_bits(input int unsigned n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_reg !== 64'h0) begin bad++; $display("FAIL reset_rx_reg: got %h want 0", rx_reg); end
    total++; if (rx_dv !== 1'b0) begin bad++; $display("FAIL reset_rx_dv: got %b want 0", rx_dv); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    rst = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_back_to_back;
    int unsigned dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_word(64'h0102030405060708);
    idle_bits(1);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL b2b_dv_count: got %0d want 1", dv_cnt - dv0); end
    total++; if (last_word !== 64'h0102030405060708) begin bad++; $display("FAIL b2b_word: got %h want 0102030405060708", last_word); end
    total++; if (dv_cyc - start_cyc !== 829) begin bad++; $display("FAIL b2b_latency: got %0d want 829", dv_cyc - start_cyc); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL b2b_err_cnt: got %h want %h", err_cnt, exp_err); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL b2b_frame_err: got %0d want 0", fe_cnt - fe0); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_false_start;
    int unsigned dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL fs_busy_during: got %b want 1", rx_busy); end
    repeat (10) @(negedge clk);
    idle_bits(2);
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL fs_dv: got %0d want 0", dv_cnt - dv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL fs_frame_err: got %0d want 0", fe_cnt - fe0); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL fs_busy_after: got %b want 0", rx_busy); end
    total++; if (rx_reg !== 64'h0102030405060708) begin bad++; $display("FAIL fs_rx_reg: got %h want 0102030405060708", rx_reg); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL fs_err_cnt: got %h want %h", err_cnt, exp_err); end
  endtask

  task automatic test_frame_error;
    int unsigned dv0, fe0;
    logic [7:0] b;
    dv0 = dv_cnt; fe0 = fe_cnt;
    b = 8'hA5;
    send_frame_raw(b, PAR_ON, ^b, 1'b0);
    idle_bits(2);
    exp_err = exp_err + 8'd1;
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL fe_pulse: got %0d want 1", fe_cnt - fe0); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL fe_err_cnt: got %h want %h", err_cnt, exp_err); end
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL fe_no_dv: got %0d want 0", dv_cnt - dv0); end
    send_word(64'h1122334455667788);
    idle_bits(1);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL fe_dv_after: got %0d want 1", dv_cnt - dv0); end
    total++; if (rx_reg !== 64'h1122334455667788) begin bad++; $display("FAIL fe_word: got %h want 1122334455667788", rx_reg); end
  endtask

  task automatic test_break;
    int unsigned dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    idle_bits(2);
    exp_err = exp_err + 8'd1;
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL brk_pulses: got %0d want 1", fe_cnt - fe0); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL brk_err_cnt: got %h want %h", err_cnt, exp_err); end
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL brk_dv: got %0d want 0", dv_cnt - dv0); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL brk_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_timeout;
    int unsigned dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h21);
    send_frame(8'h22);
    send_frame(8'h23);
    send_frame(8'h24);
    idle_bits(1);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL to_busy_pending: got %b want 1", rx_busy); end
    idle_bits(18);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL to_busy_19bits: got %b want 1", rx_busy); end
    idle_bits(2);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL to_busy_expired: got %b want 0", rx_busy); end
    send_word(64'hF0F1F2F3F4F5F6F7);
    idle_bits(1);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL to_dv: got %0d want 1", dv_cnt - dv0); end
    total++; if (last_word !== 64'hF0F1F2F3F4F5F6F7) begin bad++; $display("FAIL to_word: got %h want F0F1F2F3F4F5F6F7", last_word); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL to_err_cnt: got %h want %h", err_cnt, exp_err); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL to_frame_err: got %0d want 0", fe_cnt - fe0); end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity;
    int unsigned dv0, fe0, pe0;
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame_raw(8'h03, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    exp_err = exp_err + 8'd1;
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_pulse: got %0d want 1", pe_cnt - pe0); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL par_err_cnt: got %h want %h", err_cnt, exp_err); end
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL par_no_dv: got %0d want 0", dv_cnt - dv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL par_no_fe: got %0d want 0", fe_cnt - fe0); end
    send_word(64'hA1B2C3D4E5F60718);
    idle_bits(1);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL par_dv_after: got %0d want 1", dv_cnt - dv0); end
    total++; if (last_word !== 64'hA1B2C3D4E5F60718) begin bad++; $display("FAIL par_word: got %h want A1B2C3D4E5F60718", last_word); end
  endtask
`endif

  task automatic test_reset_mid;
    int unsigned dv0, fe0;
    logic [7:0] b;
    send_frame(8'h31);
    send_frame(8'h32);
    b  = 8'h33;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (40) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    total++; if (rx_reg !== 64'h0) begin bad++; $display("FAIL rm_rx_reg: got %h want 0", rx_reg); end
    total++; if (rx_dv !== 1'b0) begin bad++; $display("FAIL rm_rx_dv: got %b want 0", rx_dv); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rm_rx_busy: got %b want 0", rx_busy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rm_frame_err: got %b want 0", frame_err); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rm_err_cnt: got %h want 00", err_cnt); end
    rst = 1'b0;
    exp_err = '0;
    idle_bits(2);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_word(64'h5A6B7C8D9EAFB0C1);
    idle_bits(1);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL rm_dv: got %0d want 1", dv_cnt - dv0); end
    total++; if (rx_reg !== 64'h5A6B7C8D9EAFB0C1) begin bad++; $display("FAIL rm_word: got %h want 5A6B7C8D9EAFB0C1", rx_reg); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL rm_err_cnt: got %h want %h", err_cnt, exp_err); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL rm_frame_err: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_no_clash;
    total++; if (clash_cnt !== 0) begin bad++; $display("FAIL strobe_clash: got %0d want 0", clash_cnt); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_false_start;
    test_frame_error;
    test_break;
    test_timeout;
`ifdef RX_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    test_no_clash;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
